// File: rtl/neuron_alu_sequencer.sv
// Sequences an external shared ALU through multiply-accumulate over N (x, w) pairs, then a threshold compare.
// Optional bias add before the compare is enabled by defining NEURON_BIAS_EN.
//
// state | meaning
// IDLE  | waiting for start; ALU parked at pass-A with zero operands
// LOAD  | in_ready high; waiting for an (x, w) pair
// MUL   | ALU computes x_q * w_q into prod
// ADD   | ALU computes acc + prod into acc; element counted
// BIAS  | ALU computes acc + bias_q into acc (NEURON_BIAS_EN only)
// ACT   | ALU unsigned compare acc vs threshold; result captured
// DONE  | out_valid held until out_ready
module neuron_alu_sequencer #(
    parameter int NBITS = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [NBITS-1:0] threshold,
`ifdef NEURON_BIAS_EN
    input  logic [NBITS-1:0] bias,
`endif
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] in_x,
    input  logic [NBITS-1:0] in_w,
    output logic [2:0]       alu_ctrl,
    output logic [NBITS-1:0] alu_a,
    output logic [NBITS-1:0] alu_b,
    input  logic [NBITS-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_acc,
    output logic             out_fire
);

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_MUL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_ADD,
        S_ACT,
`ifdef NEURON_BIAS_EN
        S_BIAS,
`endif
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] acc, prod, x_q, w_q, thr_q;
    logic [LEN_W-1:0] count, len_q;
    logic             last_elem;
`ifdef NEURON_BIAS_EN
    logic [NBITS-1:0] bias_q;
    localparam state_t S_POST_MAC = S_BIAS;
`else
    localparam state_t S_POST_MAC = S_ACT;
`endif

    assign last_elem = (count + 1'b1) == len_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = (state_q != S_IDLE);
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_ctrl  = ALU_PASS;
        alu_a     = '0;
        alu_b     = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len != '0) ? S_LOAD : S_POST_MAC;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                alu_ctrl = ALU_MUL;
                alu_a    = x_q;
                alu_b    = w_q;
                state_d  = S_ADD;
            end
            S_ADD: begin
                alu_ctrl = ALU_ADD;
                alu_a    = acc;
                alu_b    = prod;
                state_d  = last_elem ? S_POST_MAC : S_LOAD;
            end
`ifdef NEURON_BIAS_EN
            S_BIAS: begin
                alu_ctrl = ALU_ADD;
                alu_a    = acc;
                alu_b    = bias_q;
                state_d  = S_ACT;
            end
`endif
            S_ACT: begin
                alu_ctrl = ALU_SLT;
                alu_a    = acc;
                alu_b    = thr_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers capture the ALU result in the same cycle the operands are presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            prod     <= '0;
            x_q      <= '0;
            w_q      <= '0;
            thr_q    <= '0;
            count    <= '0;
            len_q    <= '0;
            out_acc  <= '0;
            out_fire <= 1'b0;
`ifdef NEURON_BIAS_EN
            bias_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q  <= len;
                        thr_q  <= threshold;
                        acc    <= '0;
                        count  <= '0;
`ifdef NEURON_BIAS_EN
                        bias_q <= bias;
`endif
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        x_q <= in_x;
                        w_q <= in_w;
                    end
                end
                S_MUL: prod <= alu_result;
                S_ADD: begin
                    acc   <= alu_result;
                    count <= count + 1'b1;
                end
`ifdef NEURON_BIAS_EN
                S_BIAS: acc <= alu_result;
`endif
                S_ACT: begin
                    out_fire <= alu_result[0];
                    out_acc  <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_alu_sequencer.sv
// Directed vector bench for neuron_alu_sequencer with a behavioural model of the shared ALU.
// Define NEURON_BIAS_EN to exercise the bias variant.
module tb_neuron_alu_sequencer;

    localparam int NB = 32;
    localparam int LW = 8;
`ifdef NEURON_BIAS_EN
    localparam int LAT_X = 1;
`else
    localparam int LAT_X = 0;
`endif

    logic          clk = 1'b0;
    logic          reset, start, in_valid, out_ready;
    logic [LW-1:0] len;
    logic [NB-1:0] threshold, in_x, in_w, alu_a, alu_b, alu_result, out_acc;
    logic [2:0]    alu_ctrl;
    logic          busy, in_ready, out_valid, out_fire;
`ifdef NEURON_BIAS_EN
    logic [NB-1:0] bias;
`endif

    int nvec  = 0;
    int nfail = 0;

    neuron_alu_sequencer #(.NBITS(NB), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .threshold(threshold),
`ifdef NEURON_BIAS_EN
        .bias(bias),
`endif
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_fire(out_fire)
    );

    always #5 clk = ~clk;

    // Shared ALU: slt returns 0 when A < B (unsigned), 1 otherwise.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a * alu_b;
            3'b010:  alu_result = (alu_a < alu_b) ? 32'd0 : 32'd1;
            3'b111:  alu_result = alu_a;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic [LW-1:0]      len;
        logic [NB-1:0]      thr;
        logic [3:0][NB-1:0] xs;
        logic [3:0][NB-1:0] ws;
        logic [NB-1:0]      bias;
        logic [NB-1:0]      exp_acc;
        logic               exp_fire;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [LW-1:0] l, input logic [NB-1:0] t,
                           input logic [NB-1:0] x0, input logic [NB-1:0] w0,
                           input logic [NB-1:0] x1, input logic [NB-1:0] w1,
                           input logic [NB-1:0] x2, input logic [NB-1:0] w2,
                           input logic [NB-1:0] x3, input logic [NB-1:0] w3,
                           input logic [NB-1:0] b, input logic [NB-1:0] eacc, input logic efire);
        vec_t v;
        v.len = l; v.thr = t; v.bias = b;
        v.xs = {x3, x2, x1, x0};
        v.ws = {w3, w2, w1, w0};
        v.exp_acc = eacc; v.exp_fire = efire;
        vecs.push_back(v);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 60) begin
            step();
            n++;
        end
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    endtask

    // Runs one neuron with in_valid/out_ready held high; start is sampled in cycle 0.
    task automatic run_vec(input vec_t v, input string tag);
        int   cyc = 0;
        int   idx = 0;
        logic take;
        start = 1'b1; len = v.len; threshold = v.thr;
`ifdef NEURON_BIAS_EN
        bias = v.bias;
`endif
        in_valid = 1'b1; in_x = v.xs[0]; in_w = v.ws[0]; out_ready = 1'b1;
        while (!out_valid && cyc < 200) begin
            take = in_ready && in_valid;
            step();
            cyc++;
            start = 1'b0;
            if (take) begin
                idx++;
                if (idx < 4) begin
                    in_x = v.xs[idx];
                    in_w = v.ws[idx];
                end
            end
        end
        chk({tag, " latency"}, 32'(cyc), 32'(3 * int'(v.len) + 2 + LAT_X));
        chk({tag, " out_acc"}, out_acc, v.exp_acc);
        chk({tag, " out_fire"}, 32'(out_fire), 32'(v.exp_fire));
        in_valid = 1'b0;
        step();
        chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int   hs;
        int   n;
        logic take;

        // len thr | pairs (x,w) | bias | acc fire
        add_vec(8'd1, 32'd10,  32'd3, 32'd4,  32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd12, 1'b1);
        add_vec(8'd3, 32'd12,  32'd1, 32'd2,  32'd2, 32'd3, 32'd3, 32'd1, 32'd0, 32'd0, 32'd0, 32'd11, 1'b0);
        add_vec(8'd3, 32'd11,  32'd1, 32'd2,  32'd2, 32'd3, 32'd3, 32'd1, 32'd0, 32'd0, 32'd0, 32'd11, 1'b1);
        add_vec(8'd2, 32'd0,   32'hFFFF_FFFF, 32'd1, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 1'b1);
        add_vec(8'd1, 32'd1,   32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        add_vec(8'd4, 32'd100, 32'd10, 32'd2, 32'd3, 32'd3, 32'd7, 32'd5, 32'd1, 32'd1, 32'd0, 32'd65, 1'b0);
        add_vec(8'd0, 32'd0,   32'd0, 32'd0,  32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        add_vec(8'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 32'd9, 32'd2, 32'd3, 32'd0, 32'd8, 1'b0);

        reset = 1'b1; start = 1'b0; len = '0; threshold = '0; in_valid = 1'b0;
        in_x = '0; in_w = '0; out_ready = 1'b0;
`ifdef NEURON_BIAS_EN
        bias = '0;
`endif
        repeat (3) step();
        reset = 1'b0;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_acc", out_acc, 32'd0);
        chk("rst out_fire", 32'(out_fire), 32'd0);
        chk("rst alu_ctrl", 32'(alu_ctrl), 32'd7);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);

        // Back-to-back: each run starts in the cycle right after the previous leaves DONE.
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // ALU operand trace for a single pair.
        start = 1'b1; len = 8'd1; threshold = 32'd10; in_valid = 1'b1; in_x = 32'd3; in_w = 32'd4;
        out_ready = 1'b1;
        step(); start = 1'b0;
        chk("trace load in_ready", 32'(in_ready), 32'd1);
        step(); in_valid = 1'b0;
        chk("trace mul ctrl", 32'(alu_ctrl), 32'd1);
        chk("trace mul a", alu_a, 32'd3);
        chk("trace mul b", alu_b, 32'd4);
        step();
        chk("trace add ctrl", 32'(alu_ctrl), 32'd0);
        chk("trace add a", alu_a, 32'd0);
        chk("trace add b", alu_b, 32'd12);
        wait_valid("trace");
        chk("trace out_acc", out_acc, 32'd12);
        step();

        // Stalled input before the second pair.
        start = 1'b1; len = 8'd2; threshold = 32'd0; in_valid = 1'b1; in_x = 32'd5; in_w = 32'd5;
        step(); start = 1'b0;
        step(); in_valid = 1'b0;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            chk("stall in_ready", 32'(in_ready), 32'd1);
            step();
        end
        chk("stall busy", 32'(busy), 32'd1);
        in_valid = 1'b1;
        step(); in_valid = 1'b0;
        wait_valid("stall");
        chk("stall out_acc", out_acc, 32'd50);
        chk("stall out_fire", 32'(out_fire), 32'd1);
        step();

        // len = 0 with the consumer stalled; start during DONE must be ignored.
        start = 1'b1; len = 8'd0; threshold = 32'd0; out_ready = 1'b0;
        step(); start = 1'b0;
        step();
        repeat (LAT_X) step();
        chk("len0 out_valid cyc", 32'(out_valid), 32'd1);
        start = 1'b1; len = 8'd3; threshold = 32'd5;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("len0 hold valid", 32'(out_valid), 32'd1);
            chk("len0 hold acc", out_acc, 32'd0);
            chk("len0 hold fire", 32'(out_fire), 32'd1);
        end
        start = 1'b0; out_ready = 1'b1;
        step();
        chk("len0 release valid", 32'(out_valid), 32'd0);
        chk("len0 release busy", 32'(busy), 32'd0);

        // Reset during MUL of element 2.
        start = 1'b1; len = 8'd3; threshold = 32'd1; in_valid = 1'b1; in_x = 32'd1; in_w = 32'd2;
        hs = 0; n = 0;
        while (hs < 2 && n < 50) begin
            take = in_ready && in_valid;
            step(); start = 1'b0; n++;
            if (take) begin
                hs++;
                in_x = 32'd2; in_w = 32'd3;
            end
        end
        chk("midrst in MUL", 32'(alu_ctrl), 32'd1);
        reset = 1'b1; in_valid = 1'b0;
        step();
        reset = 1'b0;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst alu_ctrl", 32'(alu_ctrl), 32'd7);
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        chk("midrst out_acc", out_acc, 32'd0);
        run_vec(vecs[1], "after_rst");

`ifdef NEURON_BIAS_EN
        begin
            vec_t bv;
            bv = vecs[0];
            bv.xs[0] = 32'd2; bv.ws[0] = 32'd3; bv.bias = 32'd4; bv.thr = 32'd10;
            bv.exp_acc = 32'd10; bv.exp_fire = 1'b1;
            run_vec(bv, "bias");
            bv.len = 8'd0; bv.bias = 32'd7; bv.thr = 32'd8; bv.exp_acc = 32'd7; bv.exp_fire = 1'b0;
            run_vec(bv, "bias_len0");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
